// File: rtl/rx_stat_counter_bank.sv
// Multi-channel receive statistics counter bank: per-channel multi-bit increments,
// saturate or wrap on overflow, sticky overflow flags, global load and a registered clear-on-read port.
module rx_stat_counter_bank #(
    parameter int          WIDTH    = 16,
    parameter int          NCH      = 4,
    parameter int          AW       = 2,
    parameter int          INC_W    = 4,
    parameter logic [63:0] INIT     = 64'd1,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [NCH-1:0]         en,
    input  logic [NCH*INC_W-1:0]   inc,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    input  logic                   rd_clr,
    output logic                   rd_valid,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_ovf,
    output logic [NCH-1:0]         ovf
);

    localparam logic [WIDTH-1:0] INIT_V = INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONES   = {WIDTH{1'b1}};

    logic [WIDTH-1:0] val_q  [NCH];
    logic [WIDTH-1:0] val_d  [NCH];
    logic [WIDTH-1:0] base_s [NCH];
    logic [WIDTH:0]   sum_s  [NCH];
    logic [NCH-1:0]   ovf_q;
    logic [NCH-1:0]   ovf_d;
    logic [NCH-1:0]   clr_hit_s;

    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;
    logic             rd_ovf_q;
    logic             rd_ovf_d;

    // Per-channel next state; a clear-on-read rebases the counter so the same-cycle increment survives.
    always_comb begin
        ovf_d     = ovf_q;
        clr_hit_s = '0;
        for (int i = 0; i < NCH; i++) begin
            clr_hit_s[i] = rd_en && rd_clr && (rd_addr == AW'(i));
            base_s[i]    = clr_hit_s[i] ? INIT_V : val_q[i];
            sum_s[i]     = {1'b0, base_s[i]}
                         + {{(WIDTH + 1 - INC_W){1'b0}}, inc[i*INC_W +: INC_W]};
            val_d[i]     = val_q[i];
            if (load) begin
                val_d[i] = INIT_V;
                ovf_d[i] = 1'b0;
            end else if (en[i] && sum_s[i][WIDTH]) begin
                val_d[i] = SATURATE ? ONES : sum_s[i][WIDTH-1:0];
                ovf_d[i] = 1'b1;
            end else if (en[i]) begin
                val_d[i] = sum_s[i][WIDTH-1:0];
                ovf_d[i] = clr_hit_s[i] ? 1'b0 : ovf_q[i];
            end else begin
                val_d[i] = base_s[i];
                ovf_d[i] = clr_hit_s[i] ? 1'b0 : ovf_q[i];
            end
        end
    end

    // Read mux on pre-update state; unmapped addresses fall through to zero.
    always_comb begin
        rd_data_d = '0;
        rd_ovf_d  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            rd_data_d = (rd_addr == AW'(i)) ? val_q[i] : rd_data_d;
            rd_ovf_d  = (rd_addr == AW'(i)) ? ovf_q[i] : rd_ovf_d;
        end
    end

    // State and read-port registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                val_q[i] <= INIT_V;
            end
            ovf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                val_q[i] <= val_d[i];
            end
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_data_d;
                rd_ovf_q  <= rd_ovf_d;
            end else begin
                rd_data_q <= rd_data_q;
                rd_ovf_q  <= rd_ovf_q;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_ovf   = rd_ovf_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_rx_stat_counter_bank.sv
// Bench for rx_stat_counter_bank: a wrap and a saturate instance (WIDTH=8, NCH=4) share stimulus
// and are checked every cycle against an integer-arithmetic model, plus literal spot checks.
module tb_rx_stat_counter_bank;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        reset, load, rd_en, rd_clr;
    logic [3:0]  en;
    logic [15:0] inc;
    logic [2:0]  rd_addr;

    logic        rv_w, rv_s, ro_w, ro_s;
    logic [7:0]  rd_w, rd_s;
    logic [3:0]  ovf_w, ovf_s;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // model state, index 0 = wrap instance, 1 = saturate instance
    int m_val [2][NCH];
    bit m_ovf [2][NCH];
    bit m_rv;
    int m_rd  [2];
    bit m_ro  [2];

    always #5 clk = ~clk;

    rx_stat_counter_bank #(.WIDTH(8), .NCH(4), .AW(3), .INC_W(4), .INIT(64'd1), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .load(load), .en(en), .inc(inc), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_clr(rd_clr), .rd_valid(rv_w), .rd_data(rd_w), .rd_ovf(ro_w), .ovf(ovf_w));

    rx_stat_counter_bank #(.WIDTH(8), .NCH(4), .AW(3), .INC_W(4), .INIT(64'd1), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .load(load), .en(en), .inc(inc), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_clr(rd_clr), .rd_valid(rv_s), .rd_data(rd_s), .rd_ovf(ro_s), .ovf(ovf_s));

    // Model: counters as plain integers, overflow when the sum exceeds 255.
    always @(posedge clk) begin
        if (reset) begin
            m_rv = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_rd[k] = 0;
                m_ro[k] = 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    m_val[k][i] = 1;
                    m_ovf[k][i] = 1'b0;
                end
            end
        end else begin
            m_rv = rd_en;
            for (int k = 0; k < 2; k++) begin
                if (rd_en) begin
                    m_rd[k] = (rd_addr < 3'd4) ? m_val[k][rd_addr] : 0;
                    m_ro[k] = (rd_addr < 3'd4) ? m_ovf[k][rd_addr] : 1'b0;
                end
                for (int i = 0; i < NCH; i++) begin
                    bit clr;
                    int base, s;
                    clr  = rd_en && rd_clr && (int'(rd_addr) == i);
                    base = clr ? 1 : m_val[k][i];
                    s    = base + int'(inc[i*4 +: 4]);
                    if (load) begin
                        m_val[k][i] = 1;
                        m_ovf[k][i] = 1'b0;
                    end else if (en[i] && s > 255) begin
                        m_val[k][i] = (k == 1) ? 255 : s - 256;
                        m_ovf[k][i] = 1'b1;
                    end else begin
                        m_val[k][i] = en[i] ? s : base;
                        if (clr) m_ovf[k][i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("rd_valid_wrap", int'(rv_w), int'(m_rv));
            check("rd_valid_sat",  int'(rv_s), int'(m_rv));
            check("rd_data_wrap",  int'(rd_w), m_rd[0]);
            check("rd_data_sat",   int'(rd_s), m_rd[1]);
            check("rd_ovf_wrap",   int'(ro_w), int'(m_ro[0]));
            check("rd_ovf_sat",    int'(ro_s), int'(m_ro[1]));
            for (int i = 0; i < NCH; i++) begin
                check("ovf_wrap", int'(ovf_w[i]), int'(m_ovf[0][i]));
                check("ovf_sat",  int'(ovf_s[i]), int'(m_ovf[1][i]));
            end
        end
    end

    task automatic idle();
        load = 1'b0; en = 4'd0; inc = 16'd0; rd_en = 1'b0; rd_clr = 1'b0; rd_addr = 3'd0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One-cycle increment on a single channel.
    task automatic bump(input int ch, input int amt);
        en = 4'd0; inc = 16'd0;
        en[ch] = 1'b1;
        inc[ch*4 +: 4] = 4'(amt);
        tick();
        idle();
    endtask

    // Read a channel; on return the read data is on the outputs.
    task automatic rd(input int addr, input bit clr);
        rd_en = 1'b1; rd_addr = 3'(addr); rd_clr = clr;
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk_on = 1'b1;
        check("reset_rd_valid", int'(rv_w), 0);
        check("reset_rd_data", int'(rd_w), 0);

        // reset state of every channel
        for (int c = 0; c < 4; c++) begin
            rd(c, 1'b0);
            check("init_rd_valid", int'(rv_w), 1);
            check("init_rd_data", int'(rd_w), 1);
            check("init_rd_ovf", int'(ro_w), 0);
        end
        tick();
        check("rd_valid_one_cycle", int'(rv_w), 0);
        check("rd_data_hold", int'(rd_w), 1);

        // channel 2: 1 + 5*3 = 16
        for (int n = 0; n < 5; n++) bump(2, 3);
        rd(2, 1'b0);
        check("ch2_after_5x3", int'(rd_w), 16);
        rd(0, 1'b0); check("ch0_untouched", int'(rd_w), 1);
        rd(3, 1'b0); check("ch3_untouched", int'(rd_w), 1);

        // channel 0 to 254, then +4
        for (int n = 0; n < 16; n++) bump(0, 15);
        bump(0, 13);
        rd(0, 1'b0); check("ch0_at_254", int'(rd_w), 254);
        bump(0, 4);
        check("wrap_ovf0", int'(ovf_w[0]), 1);
        check("sat_ovf0", int'(ovf_s[0]), 1);
        rd(0, 1'b1);
        check("wrap_clr_read", int'(rd_w), 2);
        check("wrap_clr_ovf", int'(ro_w), 1);
        check("sat_clr_read", int'(rd_s), 255);
        check("ovf0_cleared", int'(ovf_w[0]), 0);
        rd(0, 1'b0); check("ch0_after_clr", int'(rd_w), 1);

        // channel 1 to 250, +15, +1
        for (int n = 0; n < 16; n++) bump(1, 15);
        bump(1, 9);
        bump(1, 15);
        bump(1, 1);
        rd(1, 1'b0);
        check("sat_hold_255", int'(rd_s), 255);
        check("sat_ovf1", int'(ro_s), 1);
        check("wrap_ch1_10", int'(rd_w), 10);
        bump(1, 0);

        // collision: clear-on-read with same-cycle increment on channel 1
        rd_en = 1'b1; rd_addr = 3'd1; rd_clr = 1'b1; en = 4'b0010; inc = 16'h0020;
        tick(); idle();
        check("collision_read", int'(rd_w), 10);
        rd(1, 1'b0); check("collision_after", int'(rd_w), 3);

        // load together with clear-on-read of channel 3 at 7
        bump(3, 6);
        load = 1'b1; rd_en = 1'b1; rd_addr = 3'd3; rd_clr = 1'b1; en = 4'b1111; inc = 16'h2222;
        tick(); idle();
        check("load_read_pre", int'(rd_w), 7);
        rd(2, 1'b0); check("load_ch2", int'(rd_w), 1);
        check("load_ovf_sat", int'(ovf_s), 0);

        // out-of-range clear-on-read
        bump(1, 4);
        rd(5, 1'b1);
        check("oob_valid", int'(rv_w), 1);
        check("oob_data", int'(rd_w), 0);
        rd(1, 1'b0); check("oob_no_clear", int'(rd_w), 5);

        // mixed multi-channel cycle
        en = 4'b1011; inc = 16'hF5A3;
        tick(); idle();
        rd(3, 1'b0); check("multi_ch3", int'(rd_w), 16);

        // reset during a pending read
        rd_en = 1'b1; rd_addr = 3'd3; reset = 1'b1;
        tick(); idle(); reset = 1'b0;
        check("reset_drop_valid", int'(rv_w), 0);
        check("reset_drop_data", int'(rd_w), 0);
        rd(3, 1'b0); check("after_reset_ch3", int'(rd_w), 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
